// File: rtl/sundial_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sundial_pkg
//  Purpose  : Shared types and constants for the shadow centroid pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
package sundial_pkg;

  typedef logic [10:0] pix_x_t;
  typedef logic [9:0]  pix_y_t;
  typedef logic [31:0] sum_t;
  typedef logic [19:0] count_t;

  // Quotient bits produced by each sequential divider, one per cycle.
  localparam int DIV_CYCLES = 32;

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    DIVIDE = 1'b1
  } state_e;

endpackage : sundial_pkg
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Purpose  : 32-bit restoring divider, one quotient bit per cycle. The first
//             bit is resolved on the start edge so done_out pulses exactly
//             DIV_CYCLES cycles after start_in.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_divider
  import sundial_pkg::*;
(
  input  logic clk_in,
  input  logic rst_in,
  input  logic start_in,
  input  sum_t dividend_in,
  input  sum_t divisor_in,
  output sum_t quotient_out,
  output sum_t remainder_out,
  output logic done_out
);

  localparam int CNT_W = $clog2(DIV_CYCLES) + 1;

  sum_t             rem_q, rem_d;
  sum_t             quo_q, quo_d;
  sum_t             dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  sum_t             src_rem, src_quo, src_dvs;
  logic [32:0]      shifted, trial;

  // One restoring step; on start the step runs on the fresh operands.
  always_comb begin
    src_rem = start_in ? '0 : rem_q;
    src_quo = start_in ? dividend_in : quo_q;
    src_dvs = start_in ? divisor_in : dvs_q;
    shifted = {src_rem, src_quo[31]};
    trial   = shifted - {1'b0, src_dvs};
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (start_in || (cnt_q != '0)) begin
      if (!trial[32]) begin
        rem_d = trial[31:0];
        quo_d = {src_quo[30:0], 1'b1};
      end else begin
        rem_d = shifted[31:0];
        quo_d = {src_quo[30:0], 1'b0};
      end
    end
    if (start_in) begin
      dvs_d = divisor_in;
      cnt_d = CNT_W'(DIV_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d  = cnt_q - CNT_W'(1);
      done_d = (cnt_q == CNT_W'(1));
    end
  end

  // Divider state registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign quotient_out  = quo_q;
  assign remainder_out = rem_q;
  assign done_out      = done_q;

endmodule : seq_divider
`default_nettype wire

// File: rtl/shadow_centroid.sv
`default_nettype none
// ============================================================================
//  Module   : shadow_centroid
//  Purpose  : Accumulates shadow pixels per frame and reports the floor
//             centroid and pixel mass a fixed 34 cycles after end of frame.
//  Revision : 1.0 - initial release
// ============================================================================
module shadow_centroid
  import sundial_pkg::*;
#(
  parameter int H_PIXELS = 1024,
  parameter int V_PIXELS = 768,
  parameter int MIN_MASS = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic        shadow_in,
  input  logic        new_frame_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic [31:0] mass_out,
  output logic        valid_out,
  output logic        busy_out,
  output logic        overrun_out
);

  state_e state_q, state_d;
  sum_t   sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  count_t cnt_q, cnt_d;
  sum_t   num_x_q, num_x_d, num_y_q, num_y_d;
  count_t den_q, den_d;
  logic   start_q, start_d;
  pix_x_t x_q, x_d;
  pix_y_t y_q, y_d;
  sum_t   mass_q, mass_d;
  logic   valid_q, valid_d;
  logic   ovr_q, ovr_d;

  logic   pix;
  sum_t   close_x, close_y;
  count_t close_cnt;
  sum_t   quo_x, quo_y, rem_x, rem_y;
  logic   done_x, done_y, low_mass;
  logic   unused_rem;

  assign pix       = valid_in & shadow_in;
  assign close_x   = sum_x_q + (pix ? sum_t'(x_in) : '0);
  assign close_y   = sum_y_q + (pix ? sum_t'(y_in) : '0);
  assign close_cnt = cnt_q + (pix ? count_t'(1) : '0);
  assign low_mass  = sum_t'(den_q) < sum_t'(MIN_MASS);

  // Next-state for FSM, accumulators, latched operands and result registers.
  always_comb begin
    state_d = state_q;
    sum_x_d = close_x;
    sum_y_d = close_y;
    cnt_d   = close_cnt;
    num_x_d = num_x_q;
    num_y_d = num_y_q;
    den_d   = den_q;
    start_d = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    mass_d  = mass_q;
    valid_d = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      ACCUM: begin
        if (new_frame_in) begin
          num_x_d = close_x;
          num_y_d = close_y;
          den_d   = close_cnt;
          sum_x_d = '0;
          sum_y_d = '0;
          cnt_d   = '0;
          start_d = 1'b1;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        // A frame closed while dividing is discarded, pixel included.
        if (new_frame_in) begin
          sum_x_d = '0;
          sum_y_d = '0;
          cnt_d   = '0;
          ovr_d   = 1'b1;
        end
        if (done_x && done_y) begin
          state_d = ACCUM;
          valid_d = 1'b1;
          if (low_mass) begin
            x_d    = '0;
            y_d    = '0;
            mass_d = '0;
          end else begin
            // Clamp is a guard only; legal pixel data keeps the mean in range.
            x_d    = (quo_x > sum_t'(H_PIXELS - 1)) ? pix_x_t'(H_PIXELS - 1) : quo_x[10:0];
            y_d    = (quo_y > sum_t'(V_PIXELS - 1)) ? pix_y_t'(V_PIXELS - 1) : quo_y[9:0];
            mass_d = sum_t'(den_q);
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= ACCUM;
    else         state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sum_x_q <= '0;
      sum_y_q <= '0;
      cnt_q   <= '0;
      num_x_q <= '0;
      num_y_q <= '0;
      den_q   <= '0;
      start_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      mass_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sum_x_q <= sum_x_d;
      sum_y_q <= sum_y_d;
      cnt_q   <= cnt_d;
      num_x_q <= num_x_d;
      num_y_q <= num_y_d;
      den_q   <= den_d;
      start_q <= start_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mass_q  <= mass_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  seq_divider u_div_x (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_q),
    .dividend_in   (num_x_q),
    .divisor_in    (sum_t'(den_q)),
    .quotient_out  (quo_x),
    .remainder_out (rem_x),
    .done_out      (done_x)
  );

  seq_divider u_div_y (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_q),
    .dividend_in   (num_y_q),
    .divisor_in    (sum_t'(den_q)),
    .quotient_out  (quo_y),
    .remainder_out (rem_y),
    .done_out      (done_y)
  );

  // Remainders are not needed for a floor centroid.
  assign unused_rem = ^{rem_x, rem_y};

  assign x_out       = x_q;
  assign y_out       = y_q;
  assign mass_out    = mass_q;
  assign valid_out   = valid_q;
  assign busy_out    = (state_q == DIVIDE);
  assign overrun_out = ovr_q;

endmodule : shadow_centroid
`default_nettype wire
